// File: rtl/vector_pkg.sv
// Shared vector types for the operand collector: register and mask word shapes
// plus the collector state encoding.
package vector_pkg;

  localparam int VLMAX = 4;

  typedef logic [VLMAX-1:0][15:0] vreg_t;
  typedef logic [VLMAX-1:0]       vmask_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VALID   = 2'd2
  } opcollect_state_t;

endpackage

// File: rtl/opc_port_slot.sv
// One operand slot: pending-request bit, capture flag, latched bank number and
// the collected data word. Used for every data port and for the mask port.
module opc_port_slot #(
  parameter int W  = 16,
  parameter int BW = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          active,
  input  logic          load,
  input  logic          load_used,
  input  logic [BW-1:0] load_bank,
  input  logic          grant,
  input  logic [W-1:0]  rdata,
  output logic          req,
  output logic          pend,
  output logic          cap,
  output logic [BW-1:0] bank,
  output logic [W-1:0]  data
);

  assign req = pend & active;

  // A grant only counts while we are actually requesting; read data lands the cycle after.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend <= 1'b0;
      cap  <= 1'b0;
      bank <= '0;
      data <= '0;
    end else if (load) begin
      pend <= load_used;
      cap  <= 1'b0;
      bank <= load_bank;
      data <= '0;
    end else begin
      if (cap) begin
        data <= rdata;
        cap  <= 1'b0;
      end
      if (req && grant) begin
        pend <= 1'b0;
        cap  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vreg_opcollect.sv
// Vector operand collector: accepts an instruction, gathers its source operands
// and mask through contended bank read ports, then presents them as one bundle.
module vreg_opcollect
  import vector_pkg::*;
#(
  parameter int NSRC            = 3,
  parameter int BANK_COUNT      = 4,
  parameter int MASK_BANK_COUNT = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [NSRC-1:0][7:0]        issue_vs,
  input  logic [NSRC-1:0]             issue_vs_used,
  input  logic [3:0]                  issue_vms,
  input  logic                        issue_vm_used,
  input  logic [7:0]                  issue_tag,
  output logic [NSRC-1:0]             REN,
  output logic [NSRC-1:0][7:0]        vs,
  input  logic [NSRC-1:0]             rgrant,
  output logic                        MREN,
  output logic [3:0]                  vms,
  input  logic                        mgrant,
  input  vreg_t [BANK_COUNT-1:0]      bank_rdata,
  input  vmask_t [MASK_BANK_COUNT-1:0] mask_rdata,
  output logic                        op_valid,
  input  logic                        op_ready,
  output vreg_t [NSRC-1:0]            op_data,
  output vmask_t                      op_mask,
  output logic [7:0]                  op_tag,
  output logic [15:0]                 conflict_cnt
);

  localparam int DBW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
  localparam int MBW = (MASK_BANK_COUNT > 1) ? $clog2(MASK_BANK_COUNT) : 1;

  opcollect_state_t state, state_nx;
  logic                   accept, active, all_done;
  logic [NSRC-1:0][7:0]   vs_q;
  logic [3:0]             vms_q;
  logic [NSRC-1:0]        pend, cap;
  logic                   mpend, mcap;
  logic [NSRC-1:0][DBW-1:0] dbank;
  logic [MBW-1:0]         mbank;
  vreg_t [NSRC-1:0]       dsel;
  vmask_t                 msel;
  logic [16:0]            cnt_inc, cnt_sum;

  assign active   = (state == COLLECT);
  assign accept   = issue_valid & issue_ready;
  assign all_done = ~(|pend) & ~mpend & ~(|cap) & ~mcap;
  assign vs       = active ? vs_q : '0;
  assign vms      = active ? vms_q : '0;

  for (genvar i = 0; i < NSRC; i++) begin : g_slot
    assign dsel[i] = bank_rdata[dbank[i]];
    opc_port_slot #(.W($bits(vreg_t)), .BW(DBW)) u_slot (
      .CLK(CLK), .RST(RST), .active(active), .load(accept),
      .load_used(issue_vs_used[i]), .load_bank(issue_vs[i][DBW-1:0]),
      .grant(rgrant[i]), .rdata(dsel[i]), .req(REN[i]), .pend(pend[i]),
      .cap(cap[i]), .bank(dbank[i]), .data(op_data[i])
    );
  end

  assign msel = mask_rdata[mbank];
  opc_port_slot #(.W($bits(vmask_t)), .BW(MBW)) u_mslot (
    .CLK(CLK), .RST(RST), .active(active), .load(accept),
    .load_used(issue_vm_used), .load_bank(issue_vms[MBW-1:0]),
    .grant(mgrant), .rdata(msel), .req(MREN), .pend(mpend),
    .cap(mcap), .bank(mbank), .data(op_mask)
  );

  // Next state; a consumed bundle can hand over straight to the next instruction.
  always_comb begin
    state_nx    = state;
    issue_ready = 1'b0;
    op_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) state_nx = COLLECT;
      end
      COLLECT: begin
        if (all_done) state_nx = VALID;
      end
      VALID: begin
        op_valid = 1'b1;
        if (op_ready) begin
          issue_ready = 1'b1;
          state_nx    = issue_valid ? COLLECT : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      vs_q   <= '0;
      vms_q  <= '0;
      op_tag <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vs_q   <= issue_vs;
        vms_q  <= issue_vms;
        op_tag <= issue_tag;
      end
    end
  end

  always_comb begin
    cnt_inc = 17'(MREN & ~mgrant);
    for (int i = 0; i < NSRC; i++) cnt_inc = cnt_inc + 17'(REN[i] & ~rgrant[i]);
    cnt_sum = {1'b0, conflict_cnt} + cnt_inc;
  end

  // Saturating count of port-cycles that asked for a read and were refused.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) conflict_cnt <= '0;
    else     conflict_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

endmodule

// File: doc/vreg_opcollect.md
VREG_OPCOLLECT -- requirements
Module: vreg_opcollect

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: CLK, RST.
REQ-002 Parameter NSRC SHALL default to 3 and set the number of data source operands, one per register-file read port 0..NSRC-1.
REQ-003 Parameter BANK_COUNT SHALL default to 4 and set the number of data banks.
REQ-004 Parameter MASK_BANK_COUNT SHALL default to 2 and set the number of mask banks.
REQ-005 The ports SHALL be, one per line, name  direction  width  meaning:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  instruction accepted when both are high
- issue_vs  in  NSRC x 8  source register indices; bank = index[1:0]
- issue_vs_used  in  NSRC  per-source used flag
- issue_vms  in  4  mask register index; bank = index[0]
- issue_vm_used  in  1  mask used flag
- issue_tag  in  8  opaque tag, returned with the operands
- REN  out  NSRC  data read request per port
- vs  out  NSRC x 8  data read index per port
- rgrant  in  NSRC  per-port read grant from the register file
- MREN  out  1  mask read request (mask port 0)
- vms  out  4  mask read index
- mgrant  in  1  mask read grant
- bank_rdata  in  BANK_COUNT x vreg_t  per-bank read data, valid the cycle after a grant
- mask_rdata  in  MASK_BANK_COUNT x vmask_t  per-bank mask data, valid the cycle after a grant
- op_valid  out  1  operand bundle valid
- op_ready  in  1  consumer accepts the bundle
- op_data  out  NSRC x vreg_t  collected operands
- op_mask  out  vmask_t  collected mask
- op_tag  out  8  tag of the bundle
- conflict_cnt  out  16  count of requested-but-ungranted port-cycles

Function
REQ-006 The FSM SHALL have three states: IDLE, COLLECT and VALID.
REQ-007 issue_ready SHALL be 1 when the state is IDLE, or when the state is VALID and op_ready=1; otherwise it SHALL be 0.
REQ-008 On acceptance the block SHALL latch the indices and the tag, load pend = issue_vs_used and mpend = issue_vm_used, clear op_data and op_mask to 0, and enter COLLECT.
REQ-009 In COLLECT, REN[i] SHALL equal pend[i] and MREN SHALL equal mpend; vs and vms SHALL carry the latched indices; REN, MREN, vs and vms SHALL be 0 in any other state.
REQ-010 When rgrant[i] is high and REN[i] is high, pend[i] SHALL clear in that cycle. On the next cycle, op_data[i] SHALL capture bank_rdata[vs[i][1:0]].
REQ-011 The mask path SHALL follow the same rule: op_mask captures mask_rdata[vms[0]] one cycle after the mask grant.
REQ-012 A grant that arrives while the port's request is low SHALL be ignored.
REQ-013 A port that is not granted SHALL keep requesting, with no limit on retries.
REQ-014 The block SHALL go from COLLECT to VALID on the first cycle where pend=0, mpend=0 and no capture is outstanding.
REQ-015 An accepted instruction with no used sources SHALL reach VALID one cycle after acceptance.
REQ-016 Minimum latency SHALL be 3 cycles from acceptance to op_valid: grant in the first COLLECT cycle, capture, then VALID.
REQ-017 op_valid SHALL be 1 only in VALID. op_data, op_mask and op_tag SHALL stay stable while op_valid=1 and op_ready=0.
REQ-018 If op_valid=1, op_ready=1 and issue_valid=1 in the same cycle, the new instruction SHALL be accepted and the state SHALL go directly to COLLECT (back-to-back, no bubble).
REQ-019 If op_valid=1, op_ready=1 and issue_valid=0, the state SHALL return to IDLE.
REQ-020 conflict_cnt SHALL increment by popcount(REN & ~rgrant) + (MREN & ~mgrant) each cycle and SHALL saturate at 16'hFFFF.
REQ-021 conflict_cnt SHALL never wrap.

Reset
REQ-022 While RST=1, asynchronously: the state SHALL be IDLE, and pend, mpend, capture flags, latched indices, op_data, op_mask, op_tag and conflict_cnt SHALL all be 0.
REQ-023 The reset values of the outputs SHALL be: issue_ready=1, REN=0, MREN=0, op_valid=0.
REQ-024 Reset asserted mid-COLLECT or mid-VALID SHALL abandon the instruction, and grants or read data arriving afterward SHALL be ignored.

Structure
REQ-025 vreg_t (VLMAX x 16-bit bf16), vmask_t (VLMAX bits), VLMAX and the opcollect_state_t enum SHALL live in vector_pkg.
REQ-026 One sub-module, opc_port_slot, SHALL hold the pend bit, the capture flag, the bank number and the data register per data port. It SHALL be instantiated NSRC times, and the mask path SHALL reuse it with width vmask_t.

Verification
REQ-027 Scenario "no conflict": issue vs={4,5,6}, all used, with rgrant=REN every cycle -> op_valid 3 cycles after acceptance, op_data[i]=bank_rdata[i] as driven, conflict_cnt=0.
REQ-028 Scenario "bank conflict": vs={0,4,8} (all bank 0), with the grant given to port 0, then 1, then 2 -> op_valid at cycle 5, op_data[2]=bank 0 data from the third read, conflict_cnt=3.
REQ-029 Scenario "mask and partial use": issue_vs_used=3'b010, vm_used=1, vms=3 -> only REN[1] and MREN asserted, op_mask=mask_rdata[1], op_data[0] and op_data[2] = 0.
REQ-030 Scenario "backpressure and back-to-back": op_ready low for 4 cycles -> bundle stable; then op_ready=1 with issue_valid=1 -> next bundle enters COLLECT with no IDLE cycle.
REQ-031 Scenario "reset mid-collect": RST pulsed while pend=3'b110 -> REN=0 and op_valid=0 immediately, a late rgrant has no effect, conflict_cnt=0.
REQ-032 Scenario "saturation": hold REN high with no grant for more than 21846 cycles on 3 ports -> conflict_cnt stops at 16'hFFFF.
